mdl_bubwr_ser: RTL and testbench

// - Bubble write serializer: sits directly downstream of the mask register SR. Loads 16-bit page words

---
 rtl/mdl_bubwr_pkg.sv | 12 +
 rtl/mdl_bubwr_slotdec.sv | 30 +++
 rtl/mdl_bubwr_ser.sv | 108 ++++++++++
 tb/tb_mdl_bubwr_ser.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mdl_bubwr_pkg.sv
// Shared types and constants for the bubble write serializer and its slot decoder.
package mdl_bubwr_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN, ST_DONE} state_t;

  localparam int ROT_PH_CH0 = 0;
  localparam int ROT_PH_CH1 = 5;
  localparam int ROT_PH_CH2 = 10;
  localparam int ROT_PH_CH3 = 15;

  localparam int NCH_2CH = 2;
  localparam int NCH_4CH = 4;
endpackage

// File: rtl/mdl_bubwr_slotdec.sv
// Rotation-phase slot decoder; the mask SR control uses the same decode so both SRs
// advance on the same MCLK edge.
module mdl_bubwr_slotdec
  import mdl_bubwr_pkg::*;
(
  input  logic [19:0]                  rot20_n,
  input  logic                         ben4_n,
  input  logic                         en,
  output logic                         slot,
  output logic [$clog2(NCH_4CH)-1:0]   ch
);
  logic unused_rot;
  assign unused_rot = ^rot20_n;

  always_comb begin
    slot = 1'b0;
    ch   = '0;
    if (en) begin
      if (!rot20_n[ROT_PH_CH0]) begin
        slot = 1'b1; ch = 2'd0;
      end else if (!rot20_n[ROT_PH_CH1]) begin
        slot = 1'b1; ch = 2'd1;
      end else if (!ben4_n && !rot20_n[ROT_PH_CH2]) begin
        slot = 1'b1; ch = 2'd2;
      end else if (!ben4_n && !rot20_n[ROT_PH_CH3]) begin
        slot = 1'b1; ch = 2'd3;
      end
    end
  end
endmodule

// File: rtl/mdl_bubwr_ser.sv
// Bubble write serializer: shifts page words out LSB-first on mask-SR slot phases,
// gating each bit with the mask SR output, one page per start.
module mdl_bubwr_ser
  import mdl_bubwr_pkg::*;
#(
  parameter int PAGE_BITS = 512
) (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_CLK2M_PCEN_n,
  input  logic [19:0] i_ROT20_n,
  input  logic        i_4BEN_n,
  input  logic        i_START,
  input  logic        i_ABORT,
  input  logic [15:0] i_DIN,
  input  logic        i_DIN_VLD,
  output logic        o_DIN_RDY,
  input  logic        i_MSKREG_SR_LSB,
  output logic [3:0]  o_BDOUT,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_UNDERRUN
);
  localparam int CW = $clog2(PAGE_BITS + 1);

  state_t          state;
  logic [15:0]     dsr, hold;
  logic            hold_full;
  logic [CW-1:0]   bitcnt;
  logic            slot, take, last_bit, word_end;
  logic [1:0]      ch;

  mdl_bubwr_slotdec u_slotdec (
    .rot20_n (i_ROT20_n),
    .ben4_n  (i_4BEN_n),
    .en      (!i_CLK2M_PCEN_n),
    .slot    (slot),
    .ch      (ch)
  );

  assign o_DIN_RDY = !hold_full && (state == ST_PRIME || state == ST_RUN);
  assign o_BUSY    = (state != ST_IDLE);
  assign take      = i_DIN_VLD && o_DIN_RDY;
  assign last_bit  = (bitcnt == CW'(PAGE_BITS - 1));
  assign word_end  = (bitcnt[3:0] == 4'hF);

  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      state      <= ST_IDLE;
      dsr        <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      bitcnt     <= '0;
      o_BDOUT    <= '0;
      o_DONE     <= 1'b0;
      o_UNDERRUN <= 1'b0;
    end else if (i_ABORT) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      o_BDOUT   <= '0;
      o_DONE    <= 1'b0;
    end else begin
      o_DONE <= 1'b0;
      case (state)
        ST_IDLE: if (i_START) begin
          state      <= ST_PRIME;
          bitcnt     <= '0;
          dsr        <= '0;
          hold_full  <= 1'b0;
          o_BDOUT    <= '0;
          o_UNDERRUN <= 1'b0;
        end
        ST_PRIME: if (take) begin
          dsr   <= i_DIN;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (take) begin
            hold      <= i_DIN;
            hold_full <= 1'b1;
          end
          if (slot) begin
            o_BDOUT[ch] <= dsr[0] & i_MSKREG_SR_LSB;
            bitcnt      <= bitcnt + CW'(1);
            if (last_bit) begin
              state     <= ST_DONE;
              o_DONE    <= 1'b1;
              hold_full <= 1'b0;
            end else if (word_end) begin
              // holding is only full here if no word could be taken this edge
              if (hold_full) begin
                dsr       <= hold;
                hold_full <= 1'b0;
              end else begin
                dsr        <= '0;
                o_UNDERRUN <= 1'b1;
              end
            end else begin
              dsr <= dsr >> 1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdl_bubwr_ser.sv
// Directed bench for mdl_bubwr_ser with a 32-bit page and a per-slot bit model.
module tb_mdl_bubwr_ser;
  localparam int PAGE = 32;

  logic        clk = 1'b0;
  logic        rst_n, pcen_n, ben4_n, start, abort, vld, msk;
  logic [19:0] rot;
  logic [15:0] din;
  logic        rdy, busy, done, underrun;
  logic [3:0]  bdout;
  logic [3:0]  exp_bd;
  int          checks = 0;
  int          errors = 0;

  mdl_bubwr_ser #(.PAGE_BITS(PAGE)) dut (
    .i_MCLK          (clk),
    .i_RST_n         (rst_n),
    .i_CLK2M_PCEN_n  (pcen_n),
    .i_ROT20_n       (rot),
    .i_4BEN_n        (ben4_n),
    .i_START         (start),
    .i_ABORT         (abort),
    .i_DIN           (din),
    .i_DIN_VLD       (vld),
    .o_DIN_RDY       (rdy),
    .i_MSKREG_SR_LSB (msk),
    .o_BDOUT         (bdout),
    .o_BUSY          (busy),
    .o_DONE          (done),
    .o_UNDERRUN      (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
    exp_bd = '0;
  endtask

  // Offer one word for a single MCLK (caller ensures the DUT is ready)
  task automatic give(input logic [15:0] w);
    din = w; vld = 1'b1; tick(); vld = 1'b0;
  endtask

  // Slots k0..k1 of a page; page bit k comes from w0 (k<16) or w1, gated by mask[k]
  task automatic run_slots(input int k0, input int k1, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [31:0] mask,
                           input bit four, input int give_at, input logic [15:0] gw);
    for (int k = k0; k <= k1; k++) begin
      int   ch;
      logic b;
      ch = four ? (k % 4) : (k % 2);
      b  = (k < 16) ? w0[k] : w1[k-16];
      rot = ~(20'd1 << (ch * 5));
      pcen_n = 1'b0;
      msk = mask[k];
      if (k == give_at) begin din = gw; vld = 1'b1; end
      tick();
      rot = '1; pcen_n = 1'b1; vld = 1'b0;
      exp_bd[ch] = b & mask[k];
      chk($sformatf("bdout_bit%0d", k), {28'd0, bdout}, {28'd0, exp_bd});
      chk($sformatf("done_bit%0d", k), {31'd0, done}, {31'd0, k == PAGE - 1});
    end
  endtask

  initial begin
    rst_n = 1'b0; pcen_n = 1'b1; rot = '1; ben4_n = 1'b1; start = 1'b0;
    abort = 1'b0; vld = 1'b0; din = '0; msk = 1'b0; exp_bd = '0;
    tick(); tick();
    chk("rst_bdout", {28'd0, bdout}, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    rst_n = 1'b1;

    // 2-channel page, two words buffered up front, mask all ones
    pulse_start();
    chk("prime_busy", {31'd0, busy}, 32'd1);
    chk("prime_rdy", {31'd0, rdy}, 32'd1);
    give(16'hA5A5);
    chk("run_rdy", {31'd0, rdy}, 32'd1);
    give(16'hFFFF);
    chk("hold_full_rdy", {31'd0, rdy}, 32'd0);
    run_slots(0, 31, 16'hA5A5, 16'hFFFF, 32'hFFFF_FFFF, 1'b0, -1, 16'h0);
    tick();
    chk("p1_done_clr", {31'd0, done}, 32'd0);
    chk("p1_idle", {31'd0, busy}, 32'd0);
    chk("p1_underrun", {31'd0, underrun}, 32'd0);

    // 4-channel page with mask 0x00FF: channels rotate 0-1-2-3
    ben4_n = 1'b0;
    pulse_start();
    give(16'hFFFF);
    give(16'hFFFF);
    run_slots(0, 31, 16'hFFFF, 16'hFFFF, 32'h0000_00FF, 1'b1, -1, 16'h0);
    tick();
    chk("p2_idle", {31'd0, busy}, 32'd0);
    ben4_n = 1'b1;

    // Underrun: only one word supplied; start while busy must be ignored
    pulse_start();
    give(16'h1234);
    run_slots(0, 14, 16'h1234, 16'h0, 32'hFFFF_FFFF, 1'b0, -1, 16'h0);
    chk("ur_before", {31'd0, underrun}, 32'd0);
    run_slots(15, 15, 16'h1234, 16'h0, 32'hFFFF_FFFF, 1'b0, -1, 16'h0);
    chk("ur_set", {31'd0, underrun}, 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy_ignored", {31'd0, underrun}, 32'd1);
    chk("start_busy_still", {31'd0, busy}, 32'd1);
    run_slots(16, 31, 16'h1234, 16'h0, 32'hFFFF_FFFF, 1'b0, -1, 16'h0);
    chk("ur_sticky", {31'd0, underrun}, 32'd1);
    tick();

    // Abort after 7 bits, then a clean page
    pulse_start();
    chk("start_clears_ur", {31'd0, underrun}, 32'd0);
    give(16'hFFFF);
    run_slots(0, 6, 16'hFFFF, 16'h0, 32'hFFFF_FFFF, 1'b0, -1, 16'h0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_bdout", {28'd0, bdout}, 32'd0);
    chk("abort_rdy", {31'd0, rdy}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    pulse_start();
    give(16'hA5A5);
    give(16'h5A5A);
    run_slots(0, 31, 16'hA5A5, 16'h5A5A, 32'hFFFF_FFFF, 1'b0, -1, 16'h0);
    tick();

    // Second word accepted on the same edge as a slot
    pulse_start();
    give(16'hC3C3);
    run_slots(0, 31, 16'hC3C3, 16'h0F0F, 32'hFFFF_FFFF, 1'b0, 5, 16'h0F0F);
    chk("same_edge_no_ur", {31'd0, underrun}, 32'd0);
    tick();

    // Reset for one MCLK mid-run
    pulse_start();
    give(16'hFFFF);
    run_slots(0, 16, 16'hFFFF, 16'h0, 32'hFFFF_FFFF, 1'b0, -1, 16'h0);
    chk("pre_rst_ur", {31'd0, underrun}, 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_bdout", {28'd0, bdout}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rdy", {31'd0, rdy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_ur", {31'd0, underrun}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
